// File: rtl/bat_regfile.sv
// ---------------------------------------------------------------------------
// bat_regfile
//
// General-purpose register file for the 16-bit bus CPU. It replaces the
// individual bidirectional register instances with one array that has a
// single combinational read port and a single write port.
//
// Each register can be loaded from the shared bus, read onto the shared bus
// or counted up/down by one (modulo 2^WIDTH). Register 0 and register 1 feed
// the ALU operands, and the last register is the output latch.
//
// Optional feature (compile-time macro BAT_REGFILE_SWAP_EN):
//   When defined, a two-cycle register exchange is built. The array has only
//   one write port, so the swap is sequenced by a small IDLE/FIN FSM and a
//   temp register:
//     accept edge : temp <- reg[SWAP_A], reg[SWAP_A] <- reg[SWAP_B],
//                   SWAP_B is latched, FSM -> FIN
//     FIN edge    : reg[latched B] <- temp, FSM -> IDLE
//   When undefined, no FSM or temp register is built, BUSY is tied low and
//   SWAP_REQ/SWAP_A/SWAP_B are ignored.
//
// Parameters:
//   WIDTH     register and bus width in bits (>= 2)
//   NUM_REGS  register count, power of two, >= 4
//
// Ports:
//   CLOCK      in   rising-edge clock for all state
//   RESET      in   synchronous, active-high reset (overrides every request)
//   BUS_IN     in   value currently on the shared bus
//   BUS_OUT    out  reg[RD_SEL] while RD_EN is high, else 0
//   BUS_DRIVE  out  equals RD_EN, gates the top-level bus mux
//   RD_EN      in   read request
//   RD_SEL     in   read index
//   WR_EN      in   load reg[WR_SEL] from BUS_IN
//   WR_SEL     in   write index
//   CNT_EN     in   count reg[CNT_SEL]
//   CNT_SEL    in   count index
//   CNT_DOWN   in   0 = +1, 1 = -1
//   SWAP_REQ   in   request exchange of reg[SWAP_A] and reg[SWAP_B]
//   SWAP_A     in   first swap index
//   SWAP_B     in   second swap index
//   ERR_CLR    in   clears ERR (a simultaneous set wins)
//   ALU_A      out  reg[0]
//   ALU_B      out  reg[1]
//   OUTPUT     out  reg[NUM_REGS-1]
//   BUSY       out  high while a swap is in its second cycle
//   ERR        out  sticky flag, a request was dropped
// ---------------------------------------------------------------------------
module bat_regfile #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] BUS_IN,
    output logic [WIDTH-1:0] BUS_OUT,
    output logic             BUS_DRIVE,
    input  logic             RD_EN,
    input  logic [SEL_W-1:0] RD_SEL,
    input  logic             WR_EN,
    input  logic [SEL_W-1:0] WR_SEL,
    input  logic             CNT_EN,
    input  logic [SEL_W-1:0] CNT_SEL,
    input  logic             CNT_DOWN,
    input  logic             SWAP_REQ,
    input  logic [SEL_W-1:0] SWAP_A,
    input  logic [SEL_W-1:0] SWAP_B,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             BUSY,
    output logic             ERR
);

    localparam logic [WIDTH-1:0] CntStep = WIDTH'(1);

    // -----------------------------------------------------------------------
    // Register array and its single write port
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q [NUM_REGS];

    logic             port_en;
    logic [SEL_W-1:0] port_idx;
    logic [WIDTH-1:0] port_data;

    // Set when any WR/CNT/SWAP request is lost this cycle.
    logic             req_drop;

    logic             err_q;
    logic             err_d;

    // -----------------------------------------------------------------------
    // Load/count arbitration, used whenever no swap owns the write port
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] cnt_result;
    logic             wr_cnt_same;
    logic             norm_en;
    logic [SEL_W-1:0] norm_idx;
    logic [WIDTH-1:0] norm_data;
    logic             norm_drop;

    // Plain WIDTH-bit add/subtract gives the required wrap in both directions.
    assign cnt_result  = CNT_DOWN ? (regs_q[CNT_SEL] - CntStep)
                                  : (regs_q[CNT_SEL] + CntStep);
    assign wr_cnt_same = (WR_SEL == CNT_SEL);

    always_comb begin
        norm_en   = 1'b0;
        norm_idx  = WR_SEL;
        norm_data = BUS_IN;
        norm_drop = 1'b0;
        if (WR_EN) begin
            norm_en   = 1'b1;
            // A count on the register being loaded is a benign collision;
            // a count on any other register is lost and must be flagged.
            norm_drop = CNT_EN && !wr_cnt_same;
        end else if (CNT_EN) begin
            norm_en   = 1'b1;
            norm_idx  = CNT_SEL;
            norm_data = cnt_result;
        end
    end

`ifdef BAT_REGFILE_SWAP_EN
    // -----------------------------------------------------------------------
    // Swap sequencer
    // -----------------------------------------------------------------------
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StFin  = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] temp_q;
    logic [WIDTH-1:0] temp_d;
    logic [SEL_W-1:0] swap_b_q;
    logic [SEL_W-1:0] swap_b_d;

    always_comb begin
        state_d   = state_q;
        temp_d    = temp_q;
        swap_b_d  = swap_b_q;
        port_en   = norm_en;
        port_idx  = norm_idx;
        port_data = norm_data;
        req_drop  = norm_drop;
        case (state_q)
            StIdle: begin
                if (SWAP_REQ) begin
                    // Swap takes the write port; load and count both lose.
                    state_d   = StFin;
                    temp_d    = regs_q[SWAP_A];
                    swap_b_d  = SWAP_B;
                    port_en   = 1'b1;
                    port_idx  = SWAP_A;
                    port_data = regs_q[SWAP_B];
                    req_drop  = WR_EN | CNT_EN;
                end
            end
            StFin: begin
                // Completing write is the only write allowed in this state.
                state_d   = StIdle;
                port_en   = 1'b1;
                port_idx  = swap_b_q;
                port_data = temp_q;
                req_drop  = WR_EN | CNT_EN | SWAP_REQ;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= StIdle;
            temp_q   <= '0;
            swap_b_q <= '0;
        end else begin
            state_q  <= state_d;
            temp_q   <= temp_d;
            swap_b_q <= swap_b_d;
        end
    end

    assign BUSY = (state_q == StFin);

`else
    // -----------------------------------------------------------------------
    // No swap support: load/count arbitration drives the port directly
    // -----------------------------------------------------------------------
    logic unused_swap;

    always_comb begin
        port_en   = norm_en;
        port_idx  = norm_idx;
        port_data = norm_data;
        req_drop  = norm_drop;
    end

    assign unused_swap = ^{SWAP_REQ, SWAP_A, SWAP_B};
    assign BUSY        = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State update
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (port_en) begin
            regs_q[port_idx] <= port_data;
        end
    end

    // Set has priority over clear when both happen in the same cycle.
    always_comb begin
        err_d = ERR_CLR ? 1'b0 : err_q;
        if (req_drop) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign BUS_OUT   = RD_EN ? regs_q[RD_SEL] : '0;
    assign BUS_DRIVE = RD_EN;
    assign ALU_A     = regs_q[0];
    assign ALU_B     = regs_q[1];
    assign OUTPUT    = regs_q[NUM_REGS-1];
    assign ERR       = err_q;

endmodule

// File: tb/tb_bat_regfile.sv
// ---------------------------------------------------------------------------
// tb_bat_regfile
//
// Self-checking bench for bat_regfile (WIDTH=16, NUM_REGS=8). A behavioural
// model (plain array plus pending-swap bookkeeping) is stepped once per clock
// edge and every visible output is compared against it each cycle. Directed
// sequences add literal expectations that pin the model. Swap scenarios are
// exercised when BAT_REGFILE_SWAP_EN is defined; otherwise the bench checks
// that swap requests are ignored.
// ---------------------------------------------------------------------------
module tb_bat_regfile;

    localparam int W = 16;
    localparam int N = 8;
    localparam int S = 3;

`ifdef BAT_REGFILE_SWAP_EN
    localparam bit SwapOn = 1'b1;
`else
    localparam bit SwapOn = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] bus_in;
    logic [W-1:0] bus_out;
    logic         bus_drive;
    logic         rd_en;
    logic [S-1:0] rd_sel;
    logic         wr_en;
    logic [S-1:0] wr_sel;
    logic         cnt_en;
    logic [S-1:0] cnt_sel;
    logic         cnt_down;
    logic         swap_req;
    logic [S-1:0] swap_a;
    logic [S-1:0] swap_b;
    logic         err_clr;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] out_latch;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_pend;
    logic [S-1:0] m_pend_idx;
    bit           m_busy;
    bit           m_err;

    bat_regfile #(.WIDTH(W), .NUM_REGS(N)) dut (
        .CLOCK    (clock),
        .RESET    (reset),
        .BUS_IN   (bus_in),
        .BUS_OUT  (bus_out),
        .BUS_DRIVE(bus_drive),
        .RD_EN    (rd_en),
        .RD_SEL   (rd_sel),
        .WR_EN    (wr_en),
        .WR_SEL   (wr_sel),
        .CNT_EN   (cnt_en),
        .CNT_SEL  (cnt_sel),
        .CNT_DOWN (cnt_down),
        .SWAP_REQ (swap_req),
        .SWAP_A   (swap_a),
        .SWAP_B   (swap_b),
        .ERR_CLR  (err_clr),
        .ALU_A    (alu_a),
        .ALU_B    (alu_b),
        .OUTPUT   (out_latch),
        .BUSY     (busy),
        .ERR      (err)
    );

    always #50 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Next model state from the rules: reset, finish a pending swap, accept a
    // swap, load, count; anything that cannot be honoured sets the error flag.
    task automatic model_step();
        bit lost;
        if (reset) begin
            for (int i = 0; i < N; i++) m_regs[i] = '0;
            m_pend = '0;
            m_busy = 1'b0;
            m_err  = 1'b0;
        end else begin
            lost = 1'b0;
            if (m_busy) begin
                m_regs[m_pend_idx] = m_pend;
                m_busy = 1'b0;
                lost = wr_en || cnt_en || swap_req;
            end else if (SwapOn && swap_req) begin
                m_pend       = m_regs[swap_a];
                m_regs[swap_a] = m_regs[swap_b];
                m_pend_idx   = swap_b;
                m_busy       = 1'b1;
                lost = wr_en || cnt_en;
            end else if (wr_en) begin
                m_regs[wr_sel] = bus_in;
                lost = cnt_en && (cnt_sel != wr_sel);
            end else if (cnt_en) begin
                if (cnt_down) m_regs[cnt_sel] = m_regs[cnt_sel] - 16'd1;
                else          m_regs[cnt_sel] = m_regs[cnt_sel] + 16'd1;
            end
            if (err_clr) m_err = 1'b0;
            if (lost)    m_err = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("cyc_bus_out", bus_out, rd_en ? m_regs[rd_sel] : 16'h0);
        check("cyc_bus_drive", bus_drive, rd_en);
        check("cyc_alu_a", alu_a, m_regs[0]);
        check("cyc_alu_b", alu_b, m_regs[1]);
        check("cyc_output", out_latch, m_regs[N-1]);
        check("cyc_busy", busy, m_busy);
        check("cyc_err", err, m_err);
    endtask

    // Compare the settled outputs, then advance model and DUT by one edge.
    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        wr_en = 0; cnt_en = 0; swap_req = 0; err_clr = 0; rd_en = 0; reset = 0;
    endtask

    task automatic wr(input logic [S-1:0] idx, input logic [W-1:0] val);
        wr_en = 1; wr_sel = idx; bus_in = val;
        tick();
        wr_en = 0;
    endtask

    task automatic cnt(input logic [S-1:0] idx, input logic down);
        cnt_en = 1; cnt_sel = idx; cnt_down = down;
        tick();
        cnt_en = 0;
    endtask

    task automatic rd_check(input string name, input logic [S-1:0] idx, input logic [W-1:0] exp);
        rd_en = 1; rd_sel = idx;
        #1;
        check(name, bus_out, exp);
        rd_en = 0;
    endtask

    task automatic swap(input logic [S-1:0] a, input logic [S-1:0] b);
        swap_req = 1; swap_a = a; swap_b = b;
        tick();
        swap_req = 0;
    endtask

    initial begin
        bus_in = '0; rd_sel = '0; wr_sel = '0; cnt_sel = '0; cnt_down = 0;
        swap_a = '0; swap_b = '0;
        clear_reqs();
        reset = 1;
        model_step();
        @(posedge clock);
        #1;
        reset = 0;
        check("init_err", err, 0);
        check("init_busy", busy, 0);
        check("init_output", out_latch, 16'h0000);

        // Preload, provoke an error, then reset
        for (int i = 0; i < N; i++) wr(S'(i), 16'hA5A5);
        check("pre_alu_a", alu_a, 16'hA5A5);
        check("pre_output", out_latch, 16'hA5A5);
        wr_en = 1; wr_sel = 3'd1; bus_in = 16'hA5A5; cnt_en = 1; cnt_sel = 3'd2;
        tick();
        clear_reqs();
        check("pre_err_set", err, 1);
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < N; i++) rd_check("rst_reg", S'(i), 16'h0000);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_b", alu_b, 16'h0000);
        check("rst_output", out_latch, 16'h0000);
        check("rst_err", err, 0);

        // Load and read
        wr(3'd3, 16'h1234);
        rd_en = 1; rd_sel = 3'd3;
        #1;
        check("rd_bus_out", bus_out, 16'h1234);
        check("rd_bus_drive", bus_drive, 1);
        rd_en = 0;
        #1;
        check("rd_idle_bus_out", bus_out, 16'h0000);
        check("rd_idle_drive", bus_drive, 0);
        // Read and write the same index: old value now, new value after edge
        rd_en = 1; rd_sel = 3'd3; wr_en = 1; wr_sel = 3'd3; bus_in = 16'h5678;
        #1;
        check("rw_same_old", bus_out, 16'h1234);
        tick();
        wr_en = 0;
        #1;
        check("rw_same_new", bus_out, 16'h5678);
        rd_en = 0;
        wr(3'd0, 16'h0A0A);
        check("ld_alu_a", alu_a, 16'h0A0A);
        wr(3'd1, 16'h0B0B);
        check("ld_alu_b", alu_b, 16'h0B0B);
        wr(3'd7, 16'h0707);
        check("ld_output", out_latch, 16'h0707);

        // Count wrap both ways, write/count collision
        wr(3'd2, 16'hFFFF);
        cnt(3'd2, 1'b0);
        rd_check("cnt_up_wrap", 3'd2, 16'h0000);
        cnt(3'd2, 1'b1);
        rd_check("cnt_dn_wrap", 3'd2, 16'hFFFF);
        cnt(3'd2, 1'b1);
        rd_check("cnt_dn", 3'd2, 16'hFFFE);
        wr_en = 1; wr_sel = 3'd2; bus_in = 16'h0042; cnt_en = 1; cnt_sel = 3'd2; cnt_down = 0;
        tick();
        clear_reqs();
        rd_check("collide_val", 3'd2, 16'h0042);
        check("collide_err", err, 0);

        // Lost count, clear, and set-wins-over-clear
        wr_en = 1; wr_sel = 3'd5; bus_in = 16'h5555; cnt_en = 1; cnt_sel = 3'd6;
        tick();
        clear_reqs();
        check("drop_err", err, 1);
        rd_check("drop_wr_val", 3'd5, 16'h5555);
        rd_check("drop_cnt_val", 3'd6, 16'h0000);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("errclr", err, 0);
        wr_en = 1; wr_sel = 3'd5; cnt_en = 1; cnt_sel = 3'd4; err_clr = 1;
        tick();
        clear_reqs();
        check("set_wins", err, 1);
        err_clr = 1;
        tick();
        err_clr = 0;

`ifdef BAT_REGFILE_SWAP_EN
        wr(3'd4, 16'h1111);
        wr(3'd5, 16'h2222);
        swap(3'd4, 3'd5);
        check("swap_busy", busy, 1);
        rd_check("swap_mid_a", 3'd4, 16'h2222);
        wr(3'd6, 16'h6666);
        check("swap_busy_end", busy, 0);
        rd_check("swap_a", 3'd4, 16'h2222);
        rd_check("swap_b", 3'd5, 16'h1111);
        rd_check("swap_wr_dropped", 3'd6, 16'h0000);
        check("swap_wr_err", err, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("swap_errclr", err, 0);
        // Same index: full two cycles, value unchanged
        swap(3'd3, 3'd3);
        check("swap_aa_busy", busy, 1);
        tick();
        rd_check("swap_aa_val", 3'd3, 16'h5678);
        check("swap_aa_err", err, 0);
        // Held request: accepted, dropped in FIN, accepted again
        swap_req = 1; swap_a = 3'd4; swap_b = 3'd5;
        tick(); tick(); tick();
        swap_req = 0;
        check("b2b_busy", busy, 1);
        check("b2b_err", err, 1);
        tick();
        rd_check("b2b_a", 3'd4, 16'h2222);
        rd_check("b2b_b", 3'd5, 16'h1111);
        err_clr = 1;
        tick();
        err_clr = 0;
        // Reset during FIN aborts the completing write
        swap(3'd4, 3'd5);
        check("rmid_busy", busy, 1);
        reset = 1;
        tick();
        reset = 0;
        check("rmid_busy_off", busy, 0);
        tick();
        rd_check("rmid_a", 3'd4, 16'h0000);
        rd_check("rmid_b", 3'd5, 16'h0000);
        check("rmid_busy_idle", busy, 0);
`else
        wr(3'd4, 16'h1111);
        wr(3'd5, 16'h2222);
        swap(3'd4, 3'd5);
        check("noswap_busy", busy, 0);
        tick();
        rd_check("noswap_a", 3'd4, 16'h1111);
        rd_check("noswap_b", 3'd5, 16'h2222);
        check("noswap_err", err, 0);
`endif

        // Mixed traffic against the model
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 63) == 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            cnt_en   = ($urandom_range(0, 2) == 0);
            swap_req = ($urandom_range(0, 3) == 0);
            err_clr  = ($urandom_range(0, 7) == 0);
            rd_en    = $urandom_range(0, 1) != 0;
            cnt_down = $urandom_range(0, 1) != 0;
            rd_sel   = S'($urandom_range(0, N-1));
            wr_sel   = S'($urandom_range(0, N-1));
            cnt_sel  = S'($urandom_range(0, N-1));
            swap_a   = S'($urandom_range(0, N-1));
            swap_b   = S'($urandom_range(0, N-1));
            bus_in   = W'($urandom);
            tick();
        end
        clear_reqs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bat_regfile.md
# bat_regfile

Parametrised general-purpose register file that replaces the per-register bidirectional register instances of the 16-bit bus CPU with one block. It holds NUM_REGS registers of WIDTH bits on a single shared-bus interface, with one read port and one write port. Each register can be loaded, read or counted up/down. Register 0 and register 1 are exported as the ALU operands, and register NUM_REGS-1 is exported as the output latch. A two-cycle register swap is sequenced internally, because the array has only one write port.

## Interface
- WIDTH, 16, register and bus width in bits (≥ 2).
- NUM_REGS, 8, register count; power of 2, ≥ 4. Derived: SEL_W = log2(NUM_REGS).

- CLOCK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUS_IN  in  WIDTH  value currently on the shared bus.
- BUS_OUT  out  WIDTH  reg[RD_SEL] when RD_EN=1, else 0.
- BUS_DRIVE  out  1  equals RD_EN; the top level uses it to gate the bus mux.
- RD_EN  in  1  read request.
- RD_SEL  in  SEL_W  read index.
- WR_EN  in  1  load reg[WR_SEL] from BUS_IN.
- WR_SEL  in  SEL_W  write index.
- CNT_EN  in  1  count reg[CNT_SEL].
- CNT_SEL  in  SEL_W  count index.
- CNT_DOWN  in  1  0 = +1, 1 = −1.
- SWAP_REQ  in  1  request an exchange of reg[SWAP_A] and reg[SWAP_B].
- SWAP_A, SWAP_B  in  SEL_W  swap indices.
- ERR_CLR  in  1  clears ERR.
- ALU_A  out  WIDTH  reg[0].
- ALU_B  out  WIDTH  reg[1].
- OUTPUT  out  WIDTH  reg[NUM_REGS-1].
- BUSY  out  1  high while a swap is in its second cycle.
- ERR  out  1  sticky flag: a request was dropped.

## Operation
**Array and read path**
- One write port. At most one register is updated per edge, except on reset.
- Read is combinational. There are no read restrictions in any state.

**FSM**
- States: IDLE, FIN.
- IDLE → FIN when SWAP_REQ=1.
- FIN → IDLE unconditionally on the next edge.
- SWAP_REQ is ignored in FIN.

**Write-port priority in IDLE**, highest first:
1. SWAP_REQ. The accept edge does temp ← reg[SWAP_A], reg[SWAP_A] ← reg[SWAP_B], and latches SWAP_B.
2. WR_EN.
3. CNT_EN.

**Write-port use in FIN**
- reg[latched B] ← temp. This is the only write in FIN.

**Dropped requests**
- Any WR_EN, CNT_EN or SWAP_REQ that loses priority or arrives in FIN is dropped and sets ERR.
- A WR_EN and CNT_EN aimed at the same register in the same cycle are a normal collision: the write wins and the count is dropped silently, with no ERR.

**ERR**
- Set by a dropped request. Cleared by ERR_CLR or RESET.
- If ERR_CLR and a set condition occur in the same cycle, set wins.

**Arithmetic**
- Counting is modulo 2^WIDTH.
- +1 from all-ones wraps to 0; −1 from 0 wraps to all-ones.

**Special cases**
- SWAP_A = SWAP_B: the swap runs its full 2 cycles and leaves the value unchanged.
- Reading and writing the same index in one cycle: BUS_OUT shows the old value; the new value is visible after the edge.

## Timing
- **Reset:** on an edge with RESET=1:
  - all registers and temp are 0, and the FSM goes to IDLE;
  - BUSY=0, ERR=0, ALU_A=ALU_B=OUTPUT=0;
  - BUS_OUT is 0 unless RD_EN is high, in which case it shows 0 from reg.
- **Reset priority:** RESET overrides every request.
- **Reset mid-swap:** a RESET during FIN aborts the swap and gives the full reset state. The second write is not performed.
- **Write/count latency:** 1 edge. The new value appears on BUS_OUT, ALU_A, ALU_B and OUTPUT after that edge.
- **Read latency:** 0 cycles, combinational from RD_EN, RD_SEL and the register state.
- **Swap latency:**
  - the accept edge moves the FSM to FIN, so BUSY=1 for exactly one cycle;
  - the completing edge returns the FSM to IDLE;
  - both registers hold their final values 2 edges after SWAP_REQ is sampled.
- **Back-to-back swaps:** a new SWAP_REQ is accepted on the cycle BUSY is 0 again. A swap can therefore be issued at most every 2 cycles.

## Configuration
- **Macro:** BAT_REGFILE_SWAP_EN.
- **Defined:**
  - the swap FSM, temp register and BUSY are implemented as described above.
- **Undefined:**
  - no FSM and no temp register are built;
  - BUSY is tied to 0;
  - SWAP_REQ, SWAP_A and SWAP_B are ignored and never set ERR;
  - WR/CNT priority and the ERR rules apply unchanged.

## Test plan
- **Reset:** preload all registers with 0xA5A5, then assert RESET for 1 cycle → every register, ALU_A, ALU_B, OUTPUT and ERR read 0x0000/0.
- **Load and read:** WR_EN, WR_SEL=3, BUS_IN=0x1234, then RD_EN with RD_SEL=3 → BUS_OUT=0x1234 and BUS_DRIVE=1. Writes to reg 0, reg 1 and reg 7 appear on ALU_A, ALU_B and OUTPUT one cycle later.
- **Count wrap:** reg2=0xFFFF, CNT_EN with CNT_DOWN=0 → 0x0000; then CNT_DOWN=1 → 0xFFFF. WR_EN and CNT_EN both aimed at reg2 with BUS_IN=0x0042 → 0x0042 and ERR=0.
- **Swap:** reg4=0x1111, reg5=0x2222, one-cycle SWAP_REQ (A=4, B=5) → BUSY=1 for one cycle; after 2 edges reg4=0x2222 and reg5=0x1111. A WR_EN during BUSY is dropped and ERR=1; ERR_CLR then gives ERR=0.
- **Reset mid-swap:** assert RESET while BUSY=1 → all registers 0, BUSY=0, and no second write occurs.
- **Without BAT_REGFILE_SWAP_EN:** a SWAP_REQ → registers unchanged, BUSY=0, ERR=0.
